dsm_dac_mc: RTL and testbench

DSM_DAC_MC -- requirements
Module: dsm_dac_mc

---
 rtl/dsm_dac_mc.sv | 173 +++++++++++++++++
 tb/tb_dsm_dac_mc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_dac_mc.sv
// rtl/dsm_dac_mc.sv - multi-channel first-order delta-sigma DAC with shared mute gain
//
// Optional feature macro: MUTE_RAMP_EN
//   defined   : gain ramps 1 LSB per sample strobe between 0 and 2^C_DAT_W
//               (states RUN, RAMP_DN, MUTED, RAMP_UP)
//   undefined : gain jumps straight to 0 or 2^C_DAT_W on the next strobe
//               (states RUN and MUTED only)
//
// Ports:
//   CK_i      in   1                 single rising-edge clock
//   XARST_i   in   1                 asynchronous active-low reset
//   DATs_i    in   C_CH_N*C_DAT_W    unsigned samples, channel k at [k*C_DAT_W +: C_DAT_W]
//   MUTE_i    in   1                 level-sensitive mute request
//   SMP_EE_o  out  1                 one-clock sample strobe for upstream logic
//   DSs_o     out  C_CH_N            1-bit delta-sigma output per channel
//   MUTED_o   out  1                 high while gain is 0 and the block is muted

module dsm_dac_mc #(
  parameter int C_F_CK  = 130_000_000,
  parameter int C_F_SMP = 12_272_727,
  parameter int C_CH_N  = 1,
  parameter int C_DAT_W = 6
) (
  input  logic                        CK_i,
  input  logic                        XARST_i,
  input  logic [C_CH_N*C_DAT_W-1:0]   DATs_i,
  input  logic                        MUTE_i,
  output logic                        SMP_EE_o,
  output logic [C_CH_N-1:0]           DSs_o,
  output logic                        MUTED_o
);

  // Rounded phase increment: round(F_SMP * 2^24 / F_CK).
  localparam longint unsigned INC_L =
    ((longint'(C_F_SMP) << 24) + longint'(C_F_CK) / 2) / longint'(C_F_CK);
  localparam logic [23:0] INC = INC_L[23:0];

  localparam int FULL_I = 1 << C_DAT_W;
  localparam logic [C_DAT_W:0] FULL = FULL_I[C_DAT_W:0];

  // An increment of 2^23 or more could wrap on consecutive clocks and merge strobes.
  generate
    if (INC_L == 0 || INC_L >= (64'd1 << 23)) begin : g_bad_inc
      $error("dsm_dac_mc: phase increment out of range");
    end
  endgenerate

  // Phase accumulator; its carry-out becomes the registered sample strobe.
  logic [23:0] phase;
  logic [24:0] phase_sum;

  assign phase_sum = {1'b0, phase} + {1'b0, INC};

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      phase    <= '0;
      SMP_EE_o <= 1'b0;
    end else begin
      phase    <= phase_sum[23:0];
      SMP_EE_o <= phase_sum[24];
    end
  end

  // Shared gain, 0 .. 2^C_DAT_W inclusive.
  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_RAMP_DN = 2'd1,
    S_MUTED   = 2'd2,
    S_RAMP_UP = 2'd3
  } state_t;

  state_t           state;
  logic [C_DAT_W:0] gain;

`ifdef MUTE_RAMP_EN
  logic [C_DAT_W:0] gain_dn;
  logic [C_DAT_W:0] gain_up;

  // Saturating one-step neighbours of the current gain.
  assign gain_dn = (gain == '0)   ? '0   : gain - 1'b1;
  assign gain_up = (gain >= FULL) ? FULL : gain + 1'b1;

  // Every move steps the gain immediately, so a reversal continues from the
  // current value without a jump and a full ramp takes exactly 2^C_DAT_W strobes.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state   <= S_MUTED;
      gain    <= '0;
      MUTED_o <= 1'b1;
    end else if (SMP_EE_o) begin
      case (state)
        S_RUN, S_RAMP_DN, S_RAMP_UP: begin
          if (MUTE_i) begin
            gain    <= gain_dn;
            state   <= (gain_dn == '0) ? S_MUTED : S_RAMP_DN;
            MUTED_o <= (gain_dn == '0);
          end else if (state != S_RUN) begin
            gain    <= gain_up;
            state   <= (gain_up == FULL) ? S_RUN : S_RAMP_UP;
            MUTED_o <= 1'b0;
          end
        end
        S_MUTED: begin
          if (!MUTE_i) begin
            gain    <= gain_up;
            state   <= (gain_up == FULL) ? S_RUN : S_RAMP_UP;
            MUTED_o <= 1'b0;
          end
        end
        default: begin
          state   <= S_MUTED;
          gain    <= '0;
          MUTED_o <= 1'b1;
        end
      endcase
    end
  end
`else
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state   <= S_MUTED;
      gain    <= '0;
      MUTED_o <= 1'b1;
    end else if (SMP_EE_o) begin
      if (MUTE_i) begin
        state   <= S_MUTED;
        gain    <= '0;
        MUTED_o <= 1'b1;
      end else begin
        state   <= S_RUN;
        gain    <= FULL;
        MUTED_o <= 1'b0;
      end
    end
  end
`endif

  // Per-channel hold, gain scaling and first-order modulator.
  for (genvar k = 0; k < C_CH_N; k++) begin : g_ch
    logic [C_DAT_W-1:0]   hold;
    logic [C_DAT_W-1:0]   eff;
    logic [C_DAT_W-1:0]   eff_nxt;
    logic [C_DAT_W:0]     acc;
    logic [2*C_DAT_W-1:0] prod;

    // hold*gain < 2^(2*C_DAT_W), so the shifted product always fits C_DAT_W bits.
    assign prod    = {{C_DAT_W{1'b0}}, hold} * {{(C_DAT_W-1){1'b0}}, gain};
    assign eff_nxt = C_DAT_W'(prod >> C_DAT_W);

    always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
        hold <= '0;
        eff  <= '0;
        acc  <= '0;
      end else begin
        if (SMP_EE_o) begin
          hold <= DATs_i[k*C_DAT_W +: C_DAT_W];
        end
        eff <= eff_nxt;
        // Clearing alongside the EFF update keeps ACC at 0 for as long as EFF
        // is 0, so a silent channel leaves no residual pulses.
        if (eff_nxt == '0) begin
          acc <= '0;
        end else begin
          acc <= {1'b0, acc[C_DAT_W-1:0]} + {1'b0, eff};
        end
      end
    end

    assign DSs_o[k] = acc[C_DAT_W];
  end

endmodule

// File: tb/tb_dsm_dac_mc.sv
// tb/tb_dsm_dac_mc.sv - self-checking bench for dsm_dac_mc

module tb_dsm_dac_mc;

  localparam int  W     = 6;
  localparam int  N     = 2;
  localparam int  FULL  = 64;
  localparam int  F_CK  = 130_000_000;
  localparam int  F_SMP = 12_272_727;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] dat;
  logic           mute;
  logic           smp;
  logic [N-1:0]   ds;
  logic           muted;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dsm_dac_mc #(
    .C_F_CK (F_CK),
    .C_F_SMP(F_SMP),
    .C_CH_N (N),
    .C_DAT_W(W)
  ) dut (
    .CK_i    (clk),
    .XARST_i (rst_n),
    .DATs_i  (dat),
    .MUTE_i  (mute),
    .SMP_EE_o(smp),
    .DSs_o   (ds),
    .MUTED_o (muted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Leaves the bench inside a strobe cycle, or reports a timeout.
  task automatic wait_strobe();
    for (int i = 0; i < 64; i++) begin
      if (smp === 1'b1) return;
      tick();
    end
    vectors++;
    assert (smp === 1'b1)
    else begin
      miscompares++;
      $error("FAIL strobe_timeout observed=%0d expected=1", smp);
    end
  endtask

  // One strobe, then the clock that acts on it.
  task automatic step();
    wait_strobe();
    tick();
  endtask

  // Reference: the pulse density numerator for a sample at a given gain.
  function automatic int eff_of(input int d, input int g);
    return (d * g) / FULL;
  endfunction

  task automatic count_highs(input int ncyc, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (ds[0] === 1'b1) c0++;
      if (ds[1] === 1'b1) c1++;
      tick();
    end
  endtask

  initial begin
    int c0, c1, d0, d1, g, cnt, dbl, lo;
    logic prev;

    rst_n = 1'b0;
    mute  = 1'b0;
    dat   = '0;
    tick();
    tick();
    check("rst_smp",   smp,      0);
    check("rst_ds",    ds,       0);
    check("rst_muted", muted,    1);
    check("rst_gain",  dut.gain, 0);

    rst_n = 1'b1;
    step();
`ifdef MUTE_RAMP_EN
    check("first_strobe_gain", dut.gain, 1);
`else
    check("first_strobe_gain", dut.gain, FULL);
`endif
    check("first_strobe_muted", muted, 0);

    // Strobe rate over 13000 clocks, and strobe width.
    lo   = int'((longint'(13000) * F_SMP) / F_CK);
    cnt  = 0;
    dbl  = 0;
    prev = 1'b0;
    for (int i = 0; i < 13000; i++) begin
      if (smp === 1'b1) begin
        cnt++;
        if (prev === 1'b1) dbl++;
      end
      prev = smp;
      tick();
    end
    check("strobe_count_in_range", (cnt == lo || cnt == lo + 1), 1);
    check("strobe_double_width", dbl, 0);
    check("run_gain", dut.gain, FULL);
    check("run_muted", muted, 0);

    // Pulse density over one 2^W window with constant samples.
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin d0 = 32; d1 = 63; end
      else if (it == 1) begin d0 = 0; d1 = 1; end
      else begin d0 = int'($urandom_range(0, 63)); d1 = int'($urandom_range(0, 63)); end
      dat = {d1[W-1:0], d0[W-1:0]};
      wait_strobe();
      tick(); tick(); tick();
      count_highs(64, c0, c1);
      check($sformatf("density_ch0_d%0d", d0), c0, eff_of(d0, FULL));
      check($sformatf("density_ch1_d%0d", d1), c1, eff_of(d1, FULL));
    end

    // Zero clamp: ch0 17 -> 0 goes silent two clocks after the strobe.
    dat = {6'd5, 6'd17};
    wait_strobe();
    tick(); tick(); tick(); tick();
    dat = {6'd5, 6'd0};
    wait_strobe();
    tick(); tick();
    count_highs(64, c0, c1);
    check("zero_clamp_ch0", c0, 0);
    check("zero_clamp_ch1", c1, 5);

`ifdef MUTE_RAMP_EN
    // Ramp down from RUN: one LSB per strobe, muted after exactly 64 strobes.
    dat  = {6'd63, 6'd63};
    mute = 1'b1;
    g    = FULL;
    for (int s = 1; s <= FULL; s++) begin
      step();
      g = (g > 0) ? g - 1 : 0;
      check($sformatf("ramp_dn_gain_s%0d", s), dut.gain, g);
      check($sformatf("ramp_dn_muted_s%0d", s), muted, (s == FULL));
    end
    tick(); tick(); tick();
    count_highs(32, c0, c1);
    check("muted_ds_ch0", c0, 0);
    check("muted_ds_ch1", c1, 0);

    // Ramp up back to RUN in 64 strobes, then the gain stays saturated.
    mute = 1'b0;
    for (int s = 1; s <= FULL; s++) begin
      step();
      g = (g < FULL) ? g + 1 : FULL;
      check($sformatf("ramp_up_gain_s%0d", s), dut.gain, g);
      check($sformatf("ramp_up_muted_s%0d", s), muted, 0);
    end
    step();
    check("run_saturated_gain", dut.gain, FULL);

    // Reversal mid ramp-down at gain 40.
    mute = 1'b1;
    for (int s = 0; s < FULL - 40; s++) step();
    check("reverse_at_40", dut.gain, 40);
    mute = 1'b0;
    step();
    check("reverse_first_up", dut.gain, 41);
    step();
    check("reverse_second_up", dut.gain, 42);
    for (int s = 0; s < FULL - 42; s++) step();
    check("reverse_back_to_full", dut.gain, FULL);

    // Reset mid-ramp leaves only the reset state behind.
    mute = 1'b1;
    for (int s = 0; s < 5; s++) step();
    check("pre_reset_gain", dut.gain, FULL - 5);
    rst_n = 1'b0;
    #1;
    check("midramp_rst_gain",  dut.gain, 0);
    check("midramp_rst_muted", muted,    1);
    check("midramp_rst_ds",    ds,       0);
    check("midramp_rst_smp",   smp,      0);
    tick();
    mute  = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_reset_ramp_start", dut.gain, 1);
`else
    // Gain jumps directly between 0 and full scale, never in between.
    dat = {6'd63, 6'd63};
    for (int it = 0; it < 12; it++) begin
      mute = (it < 2) ? (it == 0) : 1'($urandom_range(0, 1));
      step();
      check($sformatf("jump_gain_%0d", it), dut.gain, mute ? 0 : FULL);
      check($sformatf("jump_muted_%0d", it), muted, mute);
      dbl = 0;
      for (int i = 0; i < 12; i++) begin
        if (!(dut.gain === 7'd0 || dut.gain === 7'd64)) dbl++;
        tick();
      end
      check($sformatf("jump_no_intermediate_%0d", it), dbl, 0);
    end
    mute = 1'b1;
    step();
    tick(); tick(); tick();
    count_highs(32, c0, c1);
    check("muted_ds_ch0", c0, 0);
    check("muted_ds_ch1", c1, 0);

    rst_n = 1'b0;
    #1;
    check("rst_again_gain",  dut.gain, 0);
    check("rst_again_muted", muted,    1);
    tick();
    mute  = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_reset_jump", dut.gain, FULL);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
